// File: rtl/conv_stream_engine.sv
// Streaming KxK convolution engine.
// Raster-order pixels are turned into KxK windows using K-1 line buffers. Each
// window is convolved with one channel of an on-chip signed weight bank.
// Optional ReLU is applied, and results stream out under valid/ready
// backpressure.
module conv_stream_engine #(
    parameter int IMG_H  = 16,
    parameter int IMG_W  = 15,
    parameter int K      = 3,
    parameter int DATA_W = 8,
    parameter int WGT_W  = 8,
    parameter int ACC_W  = 24,
    parameter int CHAN   = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(CHAN)-1:0]    cfg_chan,
    input  logic                       cfg_relu_en,
    output logic                       busy,
    output logic                       done,
    input  logic                       w_wr_en,
    input  logic [$clog2(CHAN)-1:0]    w_wr_chan,
    input  logic [$clog2(K*K)-1:0]     w_wr_idx,
    input  logic [WGT_W-1:0]           w_wr_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_W-1:0]           out_data,
    output logic [$clog2(IMG_H)-1:0]   out_row,
    output logic [$clog2(IMG_W)-1:0]   out_col,
    output logic                       out_last
);

    localparam int CH_W = $clog2(CHAN);
    localparam int IX_W = $clog2(K*K);
    localparam int RW   = $clog2(IMG_H);
    localparam int CW   = $clog2(IMG_W);
    localparam int KK   = K * K;

    localparam logic [CH_W:0]   CHAN_L  = (CH_W+1)'(CHAN);
    localparam logic [IX_W:0]   KK_L    = (IX_W+1)'(KK);
    localparam logic [RW-1:0]   ROW_MAX = RW'(IMG_H - 1);
    localparam logic [RW-1:0]   ROW_K1  = RW'(K - 1);
    localparam logic [CW-1:0]   COL_MAX = CW'(IMG_W - 1);
    localparam logic [CW-1:0]   COL_K1  = CW'(K - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef logic [DATA_W-1:0] px_t;
    typedef logic [WGT_W-1:0]  wgt_t;

    // Pixel zero-extended, weight sign-extended. The product is kept modulo
    // 2^ACC_W, so the sum wraps naturally.
    function automatic logic [ACC_W-1:0] mul_tap(input px_t px, input wgt_t w);
        logic signed [ACC_W-1:0] px_ext;
        logic signed [ACC_W-1:0] w_ext;
        px_ext = {{(ACC_W-DATA_W){1'b0}}, px};
        w_ext  = {{(ACC_W-WGT_W){w[WGT_W-1]}}, w};
        return px_ext * w_ext;
    endfunction

    state_t            state_q, state_d;
    logic [CH_W-1:0]   chan_q, chan_d;
    logic              relu_q, relu_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    wgt_t              w_q   [CHAN][KK];
    wgt_t              w_d   [CHAN][KK];
    px_t               lb_q  [K-1][IMG_W];
    px_t               lb_d  [K-1][IMG_W];
    px_t               win_q [K][K];
    px_t               win_d [K][K];
    logic              out_valid_q, out_valid_d;
    logic [ACC_W-1:0]  out_data_q, out_data_d;
    logic [RW-1:0]     out_row_q, out_row_d;
    logic [CW-1:0]     out_col_q, out_col_d;
    logic              out_last_q, out_last_d;

    logic              in_ready_s;
    logic              px_fire_s;
    logic              out_fire_s;
    logic              last_px_s;
    logic              win_done_s;
    logic              start_ok_s;
    px_t               col_s [K];
    px_t               sh_s  [K][K];
    logic [ACC_W-1:0]  sum_s;
    logic [ACC_W-1:0]  res_s;

    // Handshake qualifiers and frame-position decodes.
    always_comb begin
        in_ready_s = (state_q == S_RUN) && (!out_valid_q || out_ready);
        px_fire_s  = in_valid && in_ready_s;
        out_fire_s = out_valid_q && out_ready;
        last_px_s  = (row_q == ROW_MAX) && (col_q == COL_MAX);
        win_done_s = px_fire_s && (row_q >= ROW_K1) && (col_q >= COL_K1);
        start_ok_s = start && ({1'b0, cfg_chan} < CHAN_L);
    end

    // Window as it will look after the current pixel: older columns shift left,
    // and the new column comes from the line buffers plus the incoming pixel.
    always_comb begin
        for (int i = 0; i < K-1; i++) begin
            col_s[i] = lb_q[i][col_q];
        end
        col_s[K-1] = in_data;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K-1; j++) begin
                sh_s[i][j] = win_q[i][j+1];
            end
            sh_s[i][K-1] = col_s[i];
        end
    end

    // Multiply-accumulate over the shifted window, then apply optional ReLU.
    always_comb begin
        sum_s = {ACC_W{1'b0}};
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                sum_s = sum_s + mul_tap(sh_s[i][j], w_q[chan_q][i*K+j]);
            end
        end
        if (relu_q && sum_s[ACC_W-1]) begin
            res_s = {ACC_W{1'b0}};
        end else begin
            res_s = sum_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok_s) state_d = S_RUN;
                else            state_d = S_IDLE;
            end
            S_RUN: begin
                if (px_fire_s && last_px_s) state_d = S_FLUSH;
                else                        state_d = S_RUN;
            end
            S_FLUSH: begin
                if (out_fire_s && out_last_q) state_d = S_DONE;
                else                          state_d = S_FLUSH;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs, registered from the next state so done and busy line up
    // with the DONE cycle.
    always_comb begin
        busy_d = (state_d == S_RUN) || (state_d == S_FLUSH);
        done_d = (state_d == S_DONE);
    end

    // Frame configuration and raster position counters.
    always_comb begin
        chan_d = chan_q;
        relu_d = relu_q;
        row_d  = row_q;
        col_d  = col_q;
        if ((state_q == S_IDLE) && start_ok_s) begin
            chan_d = cfg_chan;
            relu_d = cfg_relu_en;
            row_d  = {RW{1'b0}};
            col_d  = {CW{1'b0}};
        end else if (px_fire_s) begin
            if (col_q == COL_MAX) begin
                col_d = {CW{1'b0}};
                if (row_q == ROW_MAX) row_d = {RW{1'b0}};
                else                  row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end else begin
            col_d = col_q;
        end
    end

    // Weight bank writes are accepted only while idle, and only for in-range
    // addresses.
    always_comb begin
        w_d = w_q;
        if ((state_q == S_IDLE) && w_wr_en && ({1'b0, w_wr_chan} < CHAN_L)
            && ({1'b0, w_wr_idx} < KK_L)) begin
            w_d[w_wr_chan][w_wr_idx] = w_wr_data;
        end else begin
            w_d = w_q;
        end
    end

    // Line buffers move one row up per column, and the window register shifts
    // on every consumed pixel.
    always_comb begin
        lb_d  = lb_q;
        win_d = win_q;
        if (px_fire_s) begin
            for (int i = 0; i < K-2; i++) begin
                lb_d[i][col_q] = lb_q[i+1][col_q];
            end
            lb_d[K-2][col_q] = in_data;
            win_d = sh_s;
        end else begin
            win_d = win_q;
        end
    end

    // Output slot: loading has priority, so a new result can replace the one
    // being handed off in the same cycle.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_last_d  = out_last_q;
        if (win_done_s) begin
            out_valid_d = 1'b1;
            out_data_d  = res_s;
            out_row_d   = row_q - ROW_K1;
            out_col_d   = col_q - COL_K1;
            out_last_d  = last_px_s;
        end else if (out_fire_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Control, status and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            chan_q      <= {CH_W{1'b0}};
            relu_q      <= 1'b0;
            row_q       <= {RW{1'b0}};
            col_q       <= {CW{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= {ACC_W{1'b0}};
            out_row_q   <= {RW{1'b0}};
            out_col_q   <= {CW{1'b0}};
            out_last_q  <= 1'b0;
        end else begin
            chan_q      <= chan_d;
            relu_q      <= relu_d;
            row_q       <= row_d;
            col_q       <= col_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_last_q  <= out_last_d;
        end
    end

    // Storage arrays: weight bank, line buffers and window register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHAN; i++) begin
                for (int j = 0; j < KK; j++) begin
                    w_q[i][j] <= {WGT_W{1'b0}};
                end
            end
            for (int i = 0; i < K-1; i++) begin
                for (int j = 0; j < IMG_W; j++) begin
                    lb_q[i][j] <= {DATA_W{1'b0}};
                end
            end
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    win_q[i][j] <= {DATA_W{1'b0}};
                end
            end
        end else begin
            w_q   <= w_d;
            lb_q  <= lb_d;
            win_q <= win_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_conv_stream_engine.sv
// Self-checking bench for conv_stream_engine at default parameters.
module tb_conv_stream_engine;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  cfg_chan;
    logic        cfg_relu_en;
    logic        busy;
    logic        done;
    logic        w_wr_en;
    logic [3:0]  w_wr_chan;
    logic [3:0]  w_wr_idx;
    logic [7:0]  w_wr_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic [3:0]  out_row;
    logic [3:0]  out_col;
    logic        out_last;

    int checks = 0;
    int errors = 0;
    int tb_w [10][9];

    typedef struct {
        int          chan;
        bit          relu;
        int          ipat;
        bit          bp;
        bit          poke;
        logic [23:0] exp_first;
        logic [23:0] exp_last;
    } vec_t;

    vec_t vecs [7];

    conv_stream_engine dut (
        .clk(clk), .rst(rst), .start(start), .cfg_chan(cfg_chan),
        .cfg_relu_en(cfg_relu_en), .busy(busy), .done(done),
        .w_wr_en(w_wr_en), .w_wr_chan(w_wr_chan), .w_wr_idx(w_wr_idx),
        .w_wr_data(w_wr_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_col(out_col),
        .out_last(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
        end
    endtask

    function automatic int pix(input int ipat, input int r, input int c);
        case (ipat)
            0:       return 1;
            1:       return 255;
            2:       return (r * 15 + c) % 256;
            default: return (r * 37 + c * 11 + 5) % 256;
        endcase
    endfunction

    // Direct convolution over the source image, wrapped to 24 bits.
    function automatic logic [23:0] model(input int r, input int c, input int ch,
                                          input bit relu, input int ipat);
        int          sum;
        logic [23:0] s;
        sum = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                sum += pix(ipat, r + i, c + j) * tb_w[ch][i*3+j];
        s = sum[23:0];
        if (relu && s[23]) s = 24'd0;
        return s;
    endfunction

    // mode 0: all +1, mode 1: all -1, mode 2: centre tap 2, others 0
    task automatic load_ch(input int ch, input int mode);
        int val;
        for (int idx = 0; idx < 9; idx++) begin
            val = (mode == 0) ? 1 : (mode == 1) ? -1 : ((idx == 4) ? 2 : 0);
            @(negedge clk);
            w_wr_en   = 1'b1;
            w_wr_chan = 4'(ch);
            w_wr_idx  = 4'(idx);
            w_wr_data = 8'(val);
            tb_w[ch][idx] = val;
        end
        @(negedge clk);
        w_wr_en = 1'b0;
    endtask

    task automatic run_frame(input int chan, input bit relu, input int ipat,
                             input bit bp, input bit poke,
                             output logic [23:0] first_o, output logic [23:0] last_o);
        int          px, nout, cyc, last_cyc, viol, er, ec;
        bit          finished;
        logic [23:0] expd;
        px = 0; nout = 0; cyc = 0; last_cyc = -10; viol = 0; finished = 1'b0;
        first_o = 24'd0; last_o = 24'd0;
        @(negedge clk);
        start = 1'b1; cfg_chan = 4'(chan); cfg_relu_en = relu;
        @(negedge clk);
        start = 1'b0;
        #1 check("busy_after_start", busy, 1);
        while (cyc < 3000) begin
            if (done) begin
                finished = 1'b1;
                break;
            end
            in_valid  = (px < 240) && (bp ? ($urandom_range(0, 1) == 1) : 1'b1);
            in_data   = 8'(pix(ipat, px / 15, px % 15));
            out_ready = bp ? (cyc % 3 == 0) : 1'b1;
            if (poke && cyc == 60) begin
                start = 1'b1; cfg_chan = 4'd0;
                w_wr_en = 1'b1; w_wr_chan = 4'd7; w_wr_idx = 4'd4; w_wr_data = 8'd5;
            end else begin
                start = 1'b0; w_wr_en = 1'b0;
            end
            #1;
            if (out_valid && !out_ready && in_ready) viol++;
            if (out_valid && out_ready) begin
                er = nout / 13;
                ec = nout % 13;
                expd = model(er, ec, chan, relu, ipat);
                check($sformatf("out[%0d]", nout), {out_data, out_row, out_col, out_last},
                      {expd, 4'(er), 4'(ec), (nout == 181)});
                if (nout == 0)   first_o = out_data;
                if (nout == 181) last_o  = out_data;
                if (out_last)    last_cyc = cyc;
                nout++;
            end
            if (in_valid && in_ready) px++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; start = 1'b0; w_wr_en = 1'b0;
        check("frame_done_seen", finished, 1);
        check("out_count", nout, 182);
        check("done_after_last", cyc, last_cyc + 1);
        check("busy_at_done", busy, 0);
        check("ready_under_backpressure", viol, 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        logic [23:0] f, l;
        int px;
        vecs[0] = '{0, 1'b1, 0, 1'b0, 1'b0, 24'd9,      24'd9};
        vecs[1] = '{3, 1'b0, 1, 1'b0, 1'b0, 24'hFFF709, 24'hFFF709};
        vecs[2] = '{3, 1'b1, 1, 1'b0, 1'b0, 24'd0,      24'd0};
        vecs[3] = '{7, 1'b0, 2, 1'b0, 1'b0, 24'd32,     24'd446};
        vecs[4] = '{0, 1'b1, 0, 1'b1, 1'b0, 24'd9,      24'd9};
        vecs[5] = '{7, 1'b0, 2, 1'b0, 1'b1, 24'd32,     24'd446};
        vecs[6] = '{0, 1'b0, 2, 1'b1, 1'b0, 24'd144,    24'd2007};

        for (int i = 0; i < 10; i++)
            for (int j = 0; j < 9; j++) tb_w[i][j] = 0;

        rst = 1'b1; start = 1'b0; cfg_chan = 4'd0; cfg_relu_en = 1'b0;
        w_wr_en = 1'b0; w_wr_chan = 4'd0; w_wr_idx = 4'd0; w_wr_data = 8'd0;
        in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out", {out_valid, out_data, out_row, out_col, out_last}, 0);
        rst = 1'b0;

        // Out-of-range channel must not start a frame.
        @(negedge clk);
        start = 1'b1; cfg_chan = 4'd10;
        @(negedge clk);
        start = 1'b0;
        #1 check("bad_chan_busy", busy, 0);
        check("bad_chan_in_ready", in_ready, 0);
        repeat (3) @(negedge clk);
        check("bad_chan_busy_later", busy, 0);

        load_ch(0, 0);
        load_ch(3, 1);
        load_ch(7, 2);

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i].chan, vecs[i].relu, vecs[i].ipat, vecs[i].bp, vecs[i].poke, f, l);
            check($sformatf("vec%0d_first", i), f, vecs[i].exp_first);
            check($sformatf("vec%0d_last", i), l, vecs[i].exp_last);
        end

        // Reset after 50 pixels aborts the frame and clears the weight bank.
        @(negedge clk);
        start = 1'b1; cfg_chan = 4'd0; cfg_relu_en = 1'b1;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b1; px = 0;
        for (int k = 0; k < 200 && px < 50; k++) begin
            in_valid = 1'b1; in_data = 8'd1;
            #1 if (in_valid && in_ready) px++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("rst_px50", px, 50);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 check("midrst_busy", busy, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_done", done, 0);
        @(negedge clk);
        check("midrst_no_done", done, 0);
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < 9; j++) tb_w[i][j] = 0;

        run_frame(0, 1'b0, 0, 1'b0, 1'b0, f, l);
        check("cleared_first", f, 24'd0);
        check("cleared_last", l, 24'd0);
        load_ch(0, 0);
        run_frame(0, 1'b1, 0, 1'b0, 1'b0, f, l);
        check("reload_first", f, 24'd9);
        check("reload_last", l, 24'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_stream_engine.md
Name: conv_stream_engine

Overview:
Streaming single-layer KxK convolution engine for the NPU conv path, and the parametrised successor of the fixed two-stage array-port conv block. Pixels arrive as a raster-order valid/ready stream; the engine builds windows with K-1 line buffers and selects one output channel per frame from an on-chip weight bank. It applies optional ReLU and streams results out with backpressure. Chaining two instances reproduces the conv1 -> conv2 pipeline.

Parameters:
IMG_H, 16, input rows
IMG_W, 15, input columns
K, 3, kernel height/width (K >= 2)
DATA_W, 8, unsigned pixel width
WGT_W, 8, signed weight width
ACC_W, 24, signed accumulator/output width
CHAN, 10, number of weight channels in the bank

Ports:
clk  in  1  clock, rising-edge
rst  in  1  synchronous active-high reset
start  in  1  frame start pulse, sampled in IDLE only
cfg_chan  in  clog2(CHAN)  weight channel for the frame, latched on accepted start
cfg_relu_en  in  1  ReLU enable, latched on accepted start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at frame completion
w_wr_en  in  1  weight write strobe, honoured in IDLE only
w_wr_chan  in  clog2(CHAN)  weight channel written
w_wr_idx  in  clog2(K*K)  tap index, row*K+col
w_wr_data  in  WGT_W  signed weight
in_valid  in  1  pixel valid
in_ready  out  1  engine accepts pixel
in_data  in  DATA_W  unsigned pixel
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  ACC_W  signed result
out_row  out  clog2(IMG_H)  output row index
out_col  out  clog2(IMG_W)  output column index
out_last  out  1  marks final output of the frame

Behaviour:
- Reset: on rst=1 at a clk edge, enter IDLE. All outputs go to 0: busy, done, in_ready, out_valid, out_data, out_row, out_col, out_last. Weight bank, line buffers and counters clear to 0. Reset mid-frame aborts the frame; no done pulse.
- FSM states: IDLE -> RUN -> FLUSH -> DONE -> IDLE.
- IDLE -> RUN: on start=1 with cfg_chan < CHAN. Latch cfg_chan and cfg_relu_en; zero the row and column counters. start with cfg_chan >= CHAN is ignored.
- RUN -> FLUSH: on the handshake of pixel (IMG_H-1, IMG_W-1).
- FLUSH -> DONE: on the out_valid && out_ready handshake with out_last=1.
- DONE: lasts one cycle with done=1, then returns to IDLE.
- start outside IDLE is ignored. w_wr_en outside IDLE is ignored.
- Input handshake: in_ready = (state==RUN) && (!out_valid || out_ready). A pixel is consumed when in_valid && in_ready.
- Each consumed pixel advances the column counter, wrapping at IMG_W-1 and then advancing the row. Line buffers shift; the KxK window register updates.
- A window is complete on consuming pixel (r,c) with r >= K-1 and c >= K-1. The result is for output (r-K+1, c-K+1).
- Arithmetic: out = sum over i,j of $signed({1'b0,pixel[r-K+1+i][c-K+1+j]}) * w[cfg_chan][i*K+j], in ACC_W-bit two's complement.
- Overflow wraps modulo 2^ACC_W; there is no saturation.
- ReLU: if cfg_relu_en and the sum bit ACC_W-1 is 1, output 0.
- Latency: out_valid rises in the cycle after the completing pixel's handshake, with out_data/out_row/out_col registered.
- out_valid and its payload hold stable until out_ready. A new result may load in the same cycle as the previous handshake, giving full throughput at one pixel/cycle.
- Output count per frame: (IMG_H-K+1)*(IMG_W-K+1), which is 182 at defaults.
- out_last=1 only with output (IMG_H-K, IMG_W-K).
- done follows the out_last handshake by exactly 1 cycle. busy drops in the same cycle done pulses.
- Weights persist across frames until rewritten or reset.

Test Plan:
1. Load ch0 all taps = 1; cfg_chan=0, relu on; stream 240 pixels of value 1 with out_ready=1 -> 182 outputs, each 9, row/col raster (0,0)..(13,12). out_last on (13,12); done 1 cycle later.
2. ch3 all taps = -1; image all 255, relu off -> every out_data = -2295 (0xFFF709). Same frame with relu on -> all 0.
3. Backpressure: repeat test 1, out_ready high 1 cycle in 3, in_valid random -> identical 182-value sequence, no drops/duplicates. in_ready=0 whenever out_valid && !out_ready.
4. Channel select: ch7 centre tap (idx 4) = 2, others 0; ch0 all 1; cfg_chan=7; in[r][c]=(r*15+c) mod 256 -> out(r,c) = 2*in[r+1][c+1], e.g. out(0,0)=32.
5. Illegal ops: start with cfg_chan=10 -> busy stays 0. During RUN, pulse start and w_wr_en ch7 idx4=5 -> both ignored; frame results unchanged.
6. rst=1 for 1 cycle after 50 pixels -> next cycle busy=0, out_valid=0, in_ready=0, weights read back as 0 (all outputs 0 on the next frame). A fresh load + frame matches test 1.
